operand_fetch: RTL and testbench



---
 rtl/operand_fetch.sv | 107 ++++++++++
 tb/tb_operand_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read, writeback bypass, scoreboard hazard
// stall and a one-entry valid/ready output register toward execute.
module operand_fetch #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  output logic [4:0]       raddr1,
  output logic [4:0]       raddr2,
  input  logic [31:0]      rdata1,
  input  logic [31:0]      rdata2,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic [31:0]      wb_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic            eff_wen;
  logic            hit_rs;
  logic            hit_rt;
  logic            hit_rd;
  logic            raw_rs;
  logic            raw_rt;
  logic            waw;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;
  logic [NREG-1:0] pend_set;
  logic [NREG-1:0] pend_clr;

  assign raddr1 = in_rs;
  assign raddr2 = in_rt;

  assign eff_wen = in_wen && (in_rd != 5'd0);
  assign hit_rs  = wb_we && (wb_waddr == in_rs) && (in_rs != 5'd0);
  assign hit_rt  = wb_we && (wb_waddr == in_rt) && (in_rt != 5'd0);
  assign hit_rd  = wb_we && (wb_waddr == in_rd) && (in_rd != 5'd0);

  // A write landing this cycle resolves the hazard on that register.
  assign raw_rs = pending[in_rs] && (in_rs != 5'd0) && !hit_rs;
  assign raw_rt = pending[in_rt] && (in_rt != 5'd0) && !hit_rt;
  assign waw    = eff_wen && pending[in_rd] && !hit_rd;
  assign hazard = raw_rs || raw_rt || waw;

  assign in_ready = resetn && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Operand select: r0 reads zero, then bypass, then register file.
  always_comb begin
    opnd_a = rdata1;
    opnd_b = rdata2;
    if (in_rs == 5'd0)  opnd_a = '0;
    else if (hit_rs)    opnd_a = wb_wdata;
    if (in_rt == 5'd0)  opnd_b = '0;
    else if (hit_rt)    opnd_b = wb_wdata;
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (accept && eff_wen)             pend_set = NREG'(1) << in_rd;
    if (wb_we && (wb_waddr != 5'd0))   pend_clr = NREG'(1) << wb_waddr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      pending   <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_a     <= opnd_a;
        out_b     <= opnd_b;
        out_rd    <= in_rd;
        out_wen   <= eff_wen;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Set wins over a same-cycle clear; r0 never tracked.
      pending <= ((pending & ~pend_clr) | pend_set) & ~NREG'(1);
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic, checked
// against a register-file / in-flight-set model of the pipeline.
module tb_operand_fetch;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] pending;
  logic [31:0] stall_cnt;

  logic        in_ready4;
  logic [4:0]  raddr1_4;
  logic [4:0]  raddr2_4;
  logic        out_valid4;
  logic [31:0] out_a4;
  logic [31:0] out_b4;
  logic [4:0]  out_rd4;
  logic        out_wen4;
  logic [31:0] pending4;
  logic [3:0]  stall_cnt4;

  // Bench-owned register file, written by the bench's writeback stream.
  logic [31:0] rf [32];
  assign rdata1 = rf[in_rs];
  assign rdata2 = rf[in_rt];

  // Model state
  bit          inflight [32];
  bit          m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_rd;
  bit          m_wen;
  logic [31:0] m_stall;

  int compared;
  int mismatched;

  operand_fetch #(.CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wen(in_wen),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wen(out_wen), .pending(pending), .stall_cnt(stall_cnt)
  );

  operand_fetch #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready4),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wen(in_wen),
    .raddr1(raddr1_4), .raddr2(raddr2_4), .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid4), .out_ready(out_ready), .out_a(out_a4), .out_b(out_b4),
    .out_rd(out_rd4), .out_wen(out_wen4), .pending(pending4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit wb_writes(input logic [4:0] r);
    return wb_we && wb_waddr == r && r != 5'd0;
  endfunction

  // Latest architectural value of r as seen by an instruction this cycle.
  function automatic logic [31:0] value_of(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_writes(r)) return wb_wdata;
    return rf[r];
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return r != 5'd0 && inflight[r] && !wb_writes(r);
  endfunction

  function automatic logic [31:0] inflight_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = inflight[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) inflight[i] = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0; m_stall = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_rd", 32'(out_rd), 32'(m_rd));
    chk("out_wen", 32'(out_wen), 32'(m_wen));
    chk("pending", pending, inflight_vec());
    chk("stall_cnt", stall_cnt, m_stall);
    chk("stall_cnt4", 32'(stall_cnt4), 32'(m_stall[3:0]));
  endtask

  // One clock: inputs already applied before the rising edge.
  task automatic cycle();
    bit          writes;
    bit          exp_ready;
    bit          acc;
    logic [31:0] va;
    logic [31:0] vb;
    #1;
    writes    = in_wen && in_rd != 5'd0;
    exp_ready = resetn && !busy(in_rs) && !busy(in_rt) && !(writes && busy(in_rd))
                && (!m_valid || out_ready);
    acc = in_valid && exp_ready;
    va  = value_of(in_rs);
    vb  = value_of(in_rt);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("in_ready4", 32'(in_ready4), 32'(exp_ready));
    chk("raddr1", 32'(raddr1), 32'(in_rs));
    chk("raddr2", 32'(raddr2), 32'(in_rt));
    @(posedge clk);
    #1;
    if (!resetn) begin
      model_reset();
    end else begin
      if (wb_we && wb_waddr != 5'd0) inflight[wb_waddr] = 1'b0;
      if (acc) begin
        m_valid = 1'b1; m_a = va; m_b = vb; m_rd = in_rd; m_wen = writes;
        if (writes) inflight[in_rd] = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (in_valid && !exp_ready) m_stall = m_stall + 32'd1;
    end
    if (wb_we) rf[wb_waddr] = wb_wdata;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit wen);
    in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_wen = wen;
  endtask

  task automatic wb(input bit we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_waddr = a; wb_wdata = d;
  endtask

  logic [31:0] held_a;
  logic [31:0] base_stall;
  int          pick;

  initial begin
    compared = 0; mismatched = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hFFFF_FFFF;
    rf[1] = 32'd5;
    resetn = 1'b0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    model_reset();
    cycle();
    cycle();
    resetn = 1'b1;

    // Mid-stream reset with a held output and pending[2]
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1);
    cycle();
    chk("pre_reset_pending", pending, 32'h0000_0004);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_pending", pending, 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    cycle();
    resetn = 1'b1; out_ready = 1'b1;
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
    cycle();
    chk("first_out_a", out_a, 32'd5);

    // RAW stall on r3 resolved by same-cycle bypass
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    cycle();
    base_stall = m_stall;
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    repeat (3) cycle();
    chk("raw_stalls", stall_cnt, base_stall + 32'd3);
    wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    cycle();
    wb(1'b0, 5'd0, 32'd0);
    chk("bypass_out_a", out_a, 32'hDEAD_BEEF);
    chk("bypass_pend3", 32'(pending[3]), 32'd0);

    // r0 never reads data, never writes, never pends
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    wb(1'b1, 5'd0, 32'h1234_5678);
    base_stall = m_stall;
    cycle();
    wb(1'b0, 5'd0, 32'd0);
    chk("r0_out_a", out_a, 32'd0);
    chk("r0_out_b", out_b, 32'd0);
    chk("r0_out_wen", 32'(out_wen), 32'd0);
    chk("r0_pending", pending, 32'd0);
    chk("r0_no_stall", stall_cnt, base_stall);

    // WAW on r7 with set-wins against writeback
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    cycle();
    wb(1'b1, 5'd7, 32'h0000_0777);
    cycle();
    wb(1'b0, 5'd0, 32'd0);
    chk("setwins_pend7", 32'(pending[7]), 32'd1);
    base_stall = m_stall;
    cycle();
    chk("waw_stall", stall_cnt, base_stall + 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb(1'b1, 5'd7, 32'h0000_0778);
    cycle();
    wb(1'b0, 5'd0, 32'd0);

    // Backpressure then back-to-back drain
    drive(1'b1, 5'd4, 5'd5, 5'd0, 1'b0);
    cycle();
    held_a = out_a;
    base_stall = m_stall;
    out_ready = 1'b0;
    drive(1'b1, 5'd6, 5'd8, 5'd9, 1'b1);
    repeat (4) cycle();
    chk("bp_out_a_stable", out_a, held_a);
    chk("bp_stalls", stall_cnt, base_stall + 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 5'(20 + i), 5'd0, 1'b0);
      cycle();
      chk("b2b_out_a", out_a, rf[10 + i]);
    end

    // 17 stalls after reset wrap the 4-bit counter to 1
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    cycle();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    repeat (17) cycle();
    chk("wrap_cnt4", 32'(stall_cnt4), 32'd1);
    chk("wrap_cnt32", stall_cnt, 32'd17);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb(1'b1, 5'd5, $urandom);
    cycle();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_rs     = 5'($urandom_range(0, 7));
      in_rt     = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_wen    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      wb(1'b0, 5'd0, $urandom);
      if ($urandom_range(0, 9) < 4) begin
        pick = $urandom_range(1, 31);
        for (int k = 0; k < 32; k++) begin
          if (inflight[(pick + k) % 32]) begin
            wb(1'b1, 5'((pick + k) % 32), $urandom);
            break;
          end
        end
      end else if ($urandom_range(0, 9) == 0) begin
        wb(1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
